// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned ITER_N = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div_op(input logic [2:0] o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: 64-bit accumulator doing one shift-add (multiply)
// or one restoring shift-subtract (divide) step per enabled cycle.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                step_i,
  input  logic                is_div_i,
  input  logic [XLEN_W-1:0]   a_mag_i,
  input  logic [XLEN_W-1:0]   b_mag_i,
  output logic [2*XLEN_W-1:0] acc_o
);

  localparam int unsigned ACC_W = 2 * XLEN_W;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [XLEN_W-1:0] opb_q, opb_d;
  logic              is_div_q, is_div_d;

  logic [XLEN_W:0]   mul_sum;
  logic [XLEN_W:0]   rem_sh;
  logic              rem_ge;
  logic [XLEN_W-1:0] rem_diff;

  // Step arithmetic; the shifted partial remainder needs one extra bit.
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN_W]} + {1'b0, opb_q};
    rem_sh   = acc_q[ACC_W-1:XLEN_W-1];
    rem_ge   = (rem_sh >= {1'b0, opb_q});
    rem_diff = rem_sh[XLEN_W-1:0] - opb_q;
  end

  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    if (load_i) begin
      acc_d    = {{XLEN_W{1'b0}}, a_mag_i};
      opb_d    = b_mag_i;
      is_div_d = is_div_i;
    end else if (step_i) begin
      if (is_div_q) begin
        // Quotient bits enter at the bottom as the dividend shifts out.
        if (rem_ge) begin
          acc_d = {rem_diff, acc_q[XLEN_W-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[XLEN_W-1:0], acc_q[XLEN_W-2:0], 1'b0};
        end
      end else if (acc_q[0]) begin
        acc_d = {mul_sum, acc_q[XLEN_W-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[ACC_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: sequencing FSM, operand sign handling and
// the divide-by-zero / signed-overflow shortcuts around muldiv_core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A_in,
  input  logic [XLEN-1:0] B_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                sign_q, sign_d;
  logic                special_q, special_d;
  logic [XLEN_W-1:0]   spec_res_q, spec_res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN_W-1:0]   result_q, result_d;

  op_e                 op_in;
  logic                a_neg, b_neg;
  logic [XLEN_W-1:0]   a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic                in_sign;
  logic [XLEN_W-1:0]   in_spec_res;
  logic                load_c, step_c;

  logic [2*XLEN_W-1:0] acc;
  logic [2*XLEN_W-1:0] prod;
  logic [XLEN_W-1:0]   div_sel, div_res;
  logic [XLEN_W-1:0]   finish_res;

  // Decode the incoming request into magnitudes, result sign and shortcuts.
  always_comb begin
    op_in    = op_e'(op);
    a_neg    = A_in[XLEN_W-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_neg    = B_in[XLEN_W-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    a_mag    = a_neg ? (~A_in + 1'b1) : A_in;
    b_mag    = b_neg ? (~B_in + 1'b1) : B_in;
    in_sign  = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div_op(op) & (B_in == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) & (A_in == 32'h8000_0000) & (&B_in);
    in_spec_res = '0;
    if (div_zero) begin
      in_spec_res = op[1] ? A_in : '1;
    end else if (div_ovf) begin
      in_spec_res = op[1] ? '0 : 32'h8000_0000;
    end
  end

  muldiv_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_c),
    .step_i   (step_c),
    .is_div_i (op[2]),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .acc_o    (acc)
  );

  // Final sign fix-up and output selection used in FINISH.
  always_comb begin
    prod    = sign_q ? (~acc + 64'd1) : acc;
    div_sel = (op_q inside {OP_REM, OP_REMU}) ? acc[2*XLEN_W-1:XLEN_W] : acc[XLEN_W-1:0];
    div_res = sign_q ? (~div_sel + 1'b1) : div_sel;
    if (special_q) begin
      finish_res = spec_res_q;
    end else if (is_div_op(op_q)) begin
      finish_res = div_res;
    end else if (op_q == OP_MUL) begin
      finish_res = prod[XLEN_W-1:0];
    end else begin
      finish_res = prod[2*XLEN_W-1:XLEN_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    load_c     = 1'b0;
    step_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op_in;
          sign_d     = in_sign;
          special_d  = div_zero | div_ovf;
          spec_res_d = in_spec_res;
          cnt_d      = '0;
          busy_d     = 1'b1;
          load_c     = 1'b1;
          state_d    = (div_zero | div_ovf) ? FINISH : CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_N - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = finish_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus directed vectors.
module tb_muldiv_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a_in  = 32'd0;
  logic [31:0] b_in  = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] held        = 32'd0;
  logic        rst_at_edge = 1'b0;
  logic        started     = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A_in   (a_in),
    .B_in   (b_in),
    .busy   (busy),
    .done   (done),
    .Result (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  always @(posedge clk) begin
    rst_at_edge <= !rst_n;
    if (!rst_n) started <= 1'b1;
  end

  // Per-cycle compare against the model's queue of expected results.
  always @(negedge clk) begin
    if (started) begin
      if (rst_at_edge) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        held = 32'd0;
      end else begin
        chk("busy_done_excl", 32'(busy & done), 32'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            held = exp_q.pop_front();
            chk("model_result", result, held);
          end
        end else begin
          chk("result_hold", result, held);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    exp_q.push_back(model(o, a, b));
  endtask

  task automatic drop();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle n0 after the start cycle.
  task automatic wait_from(input string name, input logic [31:0] lit, input int lat, input int n0);
    int n;
    n = n0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk(name, result, lit);
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit, input int lat);
    @(negedge clk);
    issue(o, a, b);
    drop();
    wait_from(name, lit, lat, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_result", result, 32'd0);
    rst_n = 1'b1;

    run("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("divu_by0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2);
    run("rem_by0", 3'd6, 32'h1234, 32'd0, 32'h0000_1234, 2);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run("mulh_mix", 3'd1, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 34);
    run("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

    // Back-to-back: second start raised in the done cycle.
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    drop();
    wait_from("divu_100_7", 32'd14, 34, 1);
    issue(3'd7, 32'd100, 32'd7);
    drop();
    wait_from("remu_100_7", 32'd2, 34, 1);

    // Start pulsed during CALC with other operands must be ignored.
    @(negedge clk);
    issue(3'd0, 32'd6, 32'd7);
    drop();
    repeat (4) @(negedge clk);
    op    = 3'd4;
    a_in  = 32'd100;
    b_in  = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'h0000_0011;
    wait_from("mul_ignore", 32'd42, 34, 6);
    repeat (40) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Reset in CALC cycle 10 aborts; a start right after release is accepted.
    @(negedge clk);
    issue(3'd0, 32'h0001_0000, 32'h0000_0100);
    drop();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    issue(3'd0, 32'd3, 32'd5);
    drop();
    wait_from("mul_3x5", 32'd15, 34, 1);
    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 The block SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port A_in  input  32  rs1 operand, the dividend for divide and remainder ops.
REQ-007 The block SHALL have port B_in  input  32  rs2 operand, the divisor for divide and remainder ops.
REQ-008 The block SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid Result.
REQ-010 The block SHALL have port Result  output  32  result, held stable until the next done.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and FINISH.
REQ-012 In IDLE with start=1, the block SHALL latch op and the operand magnitudes (signed ops: |A|, |B|; MULHSU: only A is signed), record the result sign, clear the 5-bit iteration counter, and go to CALC.
REQ-013 CALC SHALL run exactly 32 cycles: a shift-add step per cycle for multiply, and a restoring shift-subtract step per cycle for divide.
REQ-014 FINISH SHALL last one cycle: it negates the result if the recorded sign is negative, selects the output, registers Result, pulses done=1, and returns to IDLE.
REQ-015 Normal latency SHALL be fixed: done is high in the 34th cycle after the cycle in which start was sampled.
REQ-016 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the 64-bit signed, signed-by-unsigned and unsigned products respectively.
REQ-017 Divide by zero SHALL skip CALC (IDLE to FINISH, done in the 2nd cycle) and return: DIV/DIVU all-ones, REM/REMU the unmodified A_in.
REQ-018 Signed overflow (DIV or REM, A_in=0x80000000, B_in=0xFFFFFFFF) SHALL skip CALC and return DIV 0x80000000, REM 0.
REQ-019 A signed remainder SHALL take the sign of the dividend; a signed quotient SHALL be negative iff the operand signs differ and the divisor is non-zero.
REQ-020 start SHALL be ignored while busy=1, and latched operands SHALL NOT be affected by input changes during CALC.
REQ-021 start may be reasserted in the cycle done=1 is high; it SHALL be accepted on the following cycle, since the FSM is then in IDLE.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and busy, done, Result and the counter SHALL all be set to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; a start in the first cycle after reset releases SHALL be accepted.

Structure
REQ-025 A shared package muldiv_pkg SHALL hold the op encoding constants, the state encoding (IDLE/CALC/FINISH) and the iteration count constant (32).
REQ-026 The iterative datapath SHALL be one sub-module, muldiv_core (64-bit accumulator/remainder register, shift-add and shift-subtract step); the FSM, sign handling and special cases SHALL live in muldiv_unit.

Verification
REQ-027 The bench SHALL cover: MUL A=7, B=-3 -> Result 0xFFFFFFEB, done exactly 34 cycles after start.
REQ-028 The bench SHALL cover: MULH/MULHU/MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF.
REQ-029 The bench SHALL cover: DIV A=-7, B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2.
REQ-030 The bench SHALL cover: DIVU and REM with B=0, A=0x1234 -> 0xFFFFFFFF and 0x1234, done in the 2nd cycle; DIV 0x80000000 / -1 -> 0x80000000.
REQ-031 The bench SHALL cover: start pulsed during CALC with different operands -> ignored, first result unchanged; back-to-back start in the done cycle -> second result correct.
REQ-032 The bench SHALL cover: rst_n=0 at CALC cycle 10 -> busy=0, done never pulses, Result=0; a new MUL 3x5 afterwards -> 15.
